uart_rx_engine: RTL and testbench

//  Parametrised UART receive engine: oversampled start detect, majority-vote bit sampling,

---
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_rx_engine.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_engine.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side delivery bundle between the UART RX engine and its consumer.
// The engine holds data/flags stable while data_valid_o is high until data_ready_i.
interface uart_rx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_o;
  logic              data_valid_o;
  logic              data_ready_i;
  logic              parity_err_o;
  logic              frame_err_o;

  modport master (
    output data_o, data_valid_o, parity_err_o, frame_err_o,
    input  data_ready_i
  );

  modport slave (
    input  data_o, data_valid_o, parity_err_o, frame_err_o,
    output data_ready_i
  );
endinterface

// File: rtl/uart_rx_engine.sv
// UART receive engine: oversampled start detect, 3-sample majority vote, runtime frame format.
// Optional break detection is compiled in when UART_RX_BREAK_DET_EN is defined.
module uart_rx_engine #(
  parameter int DATA_W = 8,
  parameter int OVS    = 16,
  parameter int DIV_W  = 16,
  parameter int LEN_W  = $clog2(DATA_W + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx_en_i,
  input  logic             rx_i,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic [LEN_W-1:0] data_len_i,
  input  logic             parity_en_i,
  input  logic             parity_odd_i,
  input  logic             stop2_i,
  uart_rx_if.master        rx_if,
  output logic             overrun_o,
  output logic             break_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {IDLE, SCAN, START, DATA, PARITY, STOP, DONE, WAIT_HIGH} state_t;

  localparam int SC_W = $clog2(OVS);
  localparam logic [SC_W-1:0] S_V0  = SC_W'(OVS/2 - 1);
  localparam logic [SC_W-1:0] S_V1  = SC_W'(OVS/2);
  localparam logic [SC_W-1:0] S_DEC = SC_W'(OVS/2 + 1);
  localparam logic [SC_W-1:0] S_END = SC_W'(OVS - 1);

  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
    if (len < LEN_W'(5) || len > LEN_W'(DATA_W)) return LEN_W'(DATA_W);
    return len;
  endfunction

  function automatic logic vote3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t            state_q, state_n;
  logic              rx_meta_p0, rxs_p1, rxs_prev_p2;
  logic [DIV_W-1:0]  tick_cnt;
  logic [SC_W-1:0]   samp_cnt;
  logic [LEN_W-1:0]  bit_cnt;
  logic [LEN_W-1:0]  len_q;
  logic              par_en_q, par_odd_q, stop2_q;
  logic              v0_q, v1_q;
  logic [DATA_W-1:0] shreg;
  logic              perr_q, ferr_q;
  logic              tick, dec, bit_end, maj, fall, start_det, last_data, last_stop, brk;

  // Stage p0/p1: two-flop synchroniser; p2 keeps the previous synchronised level
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta_p0  <= 1'b1;
      rxs_p1      <= 1'b1;
      rxs_prev_p2 <= 1'b1;
    end else begin
      rx_meta_p0  <= rx_i;
      rxs_p1      <= rx_meta_p0;
      rxs_prev_p2 <= rxs_p1;
    end
  end

  assign fall      = rxs_prev_p2 & ~rxs_p1;
  assign start_det = (state_q == SCAN) && fall;
  assign tick      = (tick_cnt == '0);
  assign dec       = tick && (samp_cnt == S_DEC);
  assign bit_end   = tick && (samp_cnt == S_END);
  assign maj       = vote3(v0_q, v1_q, rxs_p1);
  assign last_data = (bit_cnt == len_q - LEN_W'(1));
  assign last_stop = !stop2_q || bit_cnt[0];
  assign busy_o    = !((state_q == IDLE) || (state_q == SCAN));

  // Counters restart on start detect so tick 0 lands right after the edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      samp_cnt <= '0;
    end else if (start_det) begin
      tick_cnt <= '0;
      samp_cnt <= '0;
    end else begin
      tick_cnt <= tick ? baud_div_i : tick_cnt - DIV_W'(1);
      if (tick) samp_cnt <= (samp_cnt == S_END) ? '0 : samp_cnt + SC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:      if (rx_en_i) state_n = SCAN;
      SCAN:      if (fall) state_n = START;
      START: begin
        if (dec && maj)   state_n = SCAN;
        else if (bit_end) state_n = DATA;
      end
      DATA:      if (bit_end && last_data) state_n = par_en_q ? PARITY : STOP;
      PARITY:    if (bit_end) state_n = STOP;
      STOP:      if (dec && last_stop) state_n = DONE;
      DONE:      state_n = (brk || !rxs_p1) ? WAIT_HIGH : SCAN;
      WAIT_HIGH: if (rxs_p1) state_n = SCAN;
      default:   state_n = IDLE;
    endcase
    if (!rx_en_i && state_q != DONE) state_n = IDLE;
  end

  // Frame assembly and delivery; flags accumulate per frame and load at DONE
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_if.data_o       <= '0;
      rx_if.data_valid_o <= 1'b0;
      rx_if.parity_err_o <= 1'b0;
      rx_if.frame_err_o  <= 1'b0;
      overrun_o          <= 1'b0;
      break_o            <= 1'b0;
      bit_cnt            <= '0;
      perr_q             <= 1'b0;
      ferr_q             <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      break_o   <= 1'b0;
      if (rx_if.data_valid_o && rx_if.data_ready_i) rx_if.data_valid_o <= 1'b0;
      if (start_det) begin
        len_q     <= sat_len(data_len_i);
        par_en_q  <= parity_en_i;
        par_odd_q <= parity_odd_i;
        stop2_q   <= stop2_i;
        bit_cnt   <= '0;
        shreg     <= '0;
        perr_q    <= 1'b0;
        ferr_q    <= 1'b0;
      end
      if (tick && samp_cnt == S_V0) v0_q <= rxs_p1;
      if (tick && samp_cnt == S_V1) v1_q <= rxs_p1;
      unique case (state_q)
        DATA: begin
          if (dec)
            for (int i = 0; i < DATA_W; i++)
              if (LEN_W'(i) == bit_cnt) shreg[i] <= maj;
          if (bit_end) bit_cnt <= last_data ? '0 : bit_cnt + LEN_W'(1);
        end
        PARITY: if (dec) perr_q <= maj ^ (^shreg) ^ par_odd_q;
        STOP: begin
          if (dec && !maj) ferr_q <= 1'b1;
          if (bit_end)     bit_cnt <= bit_cnt + LEN_W'(1);
        end
        DONE: begin
          if (brk) begin
            break_o <= 1'b1;
          end else if (!rx_if.data_valid_o || rx_if.data_ready_i) begin
            rx_if.data_o       <= shreg;
            rx_if.parity_err_o <= perr_q;
            rx_if.frame_err_o  <= ferr_q;
            rx_if.data_valid_o <= 1'b1;
          end else begin
            overrun_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  logic all_zero_q;

  // Cleared by any 1 voted in data, parity or the first stop bit
  always_ff @(posedge clk) begin
    if (!reset_n)  all_zero_q <= 1'b0;
    else if (start_det) all_zero_q <= 1'b1;
    else if (dec && maj && (state_q == DATA || state_q == PARITY ||
                            (state_q == STOP && bit_cnt == '0)))
      all_zero_q <= 1'b0;
  end

  assign brk = all_zero_q;
`else
  assign brk = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed plus randomized bench for uart_rx_engine (OVS=16, baud_div_i=0, DATA_W=8).
// Expected frames come from a frame-level reference function; outputs are sampled on negedge.
module tb_uart_rx_engine;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_en_i;
  logic        rx_i;
  logic [15:0] baud_div_i;
  logic [3:0]  data_len_i;
  logic        parity_en_i, parity_odd_i, stop2_i;
  logic        overrun_o, break_o, busy_o;

  uart_rx_if #(.DATA_W(8)) rx_if ();

  uart_rx_engine #(.DATA_W(8), .OVS(16), .DIV_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .rx_en_i(rx_en_i), .rx_i(rx_i),
    .baud_div_i(baud_div_i), .data_len_i(data_len_i), .parity_en_i(parity_en_i),
    .parity_odd_i(parity_odd_i), .stop2_i(stop2_i), .rx_if(rx_if),
    .overrun_o(overrun_o), .break_o(break_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0, fails = 0;
  int rd_idx = 0;
  int valid_cycles = 0, ovr_cnt = 0, brk_cnt = 0, busy_cycles = 0;
  logic [9:0] rcv_q[$];

  always @(negedge clk) begin
    if (rx_if.data_valid_o && rx_if.data_ready_i)
      rcv_q.push_back({rx_if.parity_err_o, rx_if.frame_err_o, rx_if.data_o});
    if (rx_if.data_valid_o) valid_cycles++;
    if (overrun_o) ovr_cnt++;
    if (break_o) brk_cnt++;
    if (busy_o) busy_cycles++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_i = b;
    cyc(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input int n, input logic pen, input logic pbit,
                            input logic s1, input logic s2, input logic two);
    send_bit(1'b0);
    for (int i = 0; i < n; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    send_bit(s1);
    if (two) send_bit(s2);
    rx_i = 1'b1;
    cyc(24);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    check({tag, "_count"}, rcv_q.size(), rd_idx + 1);
    if (rcv_q.size() > rd_idx) begin
      check({tag, "_data"}, rcv_q[rd_idx][7:0], d);
      check({tag, "_perr"}, rcv_q[rd_idx][9], pe);
      check({tag, "_ferr"}, rcv_q[rd_idx][8], fe);
      rd_idx++;
    end
  endtask

  // Returns {is_break, parity_err, frame_err, data}
  function automatic logic [10:0] ref_frame(input logic [7:0] d, input int len_cfg, input logic pen,
                                            input logic odd, input logic pbit, input logic s1,
                                            input logic s2, input logic two);
    int n;
    logic [7:0] dm;
    logic pe, fe, brk;
    n   = (len_cfg < 5 || len_cfg > 8) ? 8 : len_cfg;
    dm  = d & 8'((1 << n) - 1);
    pe  = pen && (pbit != ((^dm) ^ odd));
    fe  = !s1 || (two && !s2);
    brk = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    brk = (dm == 8'h00) && (!pen || !pbit) && !s1;
`endif
    return {brk, pe, fe, dm};
  endfunction

  initial begin
    int vc0, oc0, bc0, bu0, n0;
    logic [10:0] exp;
    logic [7:0] d;
    int len_cfg, n;
    logic pen, odd, two, pbit, s1, s2;

    rx_i = 1'b1; rx_en_i = 1'b1; reset_n = 1'b0; baud_div_i = 16'd0;
    data_len_i = 4'd8; parity_en_i = 1'b0; parity_odd_i = 1'b0; stop2_i = 1'b0;
    rx_if.data_ready_i = 1'b1;
    cyc(4);
    check("rst_data", rx_if.data_o, 8'h00);
    check("rst_valid", rx_if.data_valid_o, 1'b0);
    check("rst_perr", rx_if.parity_err_o, 1'b0);
    check("rst_ferr", rx_if.frame_err_o, 1'b0);
    check("rst_flags", {overrun_o, break_o, busy_o}, 3'b000);
    reset_n = 1'b1;
    cyc(4);

    // 8N1 0xA5
    vc0 = valid_cycles;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_frame("a5", 8'hA5, 1'b0, 1'b0);
    check("a5_valid_cycles", valid_cycles - vc0, 1);
    check("a5_busy_after", busy_o, 1'b0);

    // 7E1, wrong then right parity
    data_len_i = 4'd7; parity_en_i = 1'b1;
    send_frame(8'h55, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_frame("par_bad", 8'h55, 1'b1, 1'b0);
    send_frame(8'h55, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_frame("par_ok", 8'h55, 1'b0, 1'b0);
    data_len_i = 4'd8; parity_en_i = 1'b0;

    // Short glitch is a false start
    vc0 = valid_cycles; bu0 = busy_cycles;
    rx_i = 1'b0; cyc(4); rx_i = 1'b1; cyc(40);
    check("glitch_valid", valid_cycles - vc0, 0);
    check("glitch_busy_seen", (busy_cycles - bu0) > 0, 1'b1);
    check("glitch_busy_now", busy_o, 1'b0);

    // Overrun with consumer stalled
    rx_if.data_ready_i = 1'b0; oc0 = ovr_cnt;
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h34, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("ovr_data", rx_if.data_o, 8'h12);
    check("ovr_valid", rx_if.data_valid_o, 1'b1);
    check("ovr_pulses", ovr_cnt - oc0, 1);
    rx_if.data_ready_i = 1'b1;
    cyc(1);
    check("ovr_valid_drop", rx_if.data_valid_o, 1'b0);
    expect_frame("ovr_first", 8'h12, 1'b0, 1'b0);
    check("ovr_no_second", rcv_q.size(), rd_idx);

    // 8N2 with bad second stop
    stop2_i = 1'b1;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_frame("stop2", 8'h5A, 1'b0, 1'b1);
    stop2_i = 1'b0;

    // Break: 13 low bit-times
    bc0 = brk_cnt; n0 = rcv_q.size();
    rx_i = 1'b0; cyc(13 * 16);
    check("brk_busy_low", busy_o, 1'b1);
    rx_i = 1'b1; cyc(40);
`ifdef UART_RX_BREAK_DET_EN
    check("brk_pulse", brk_cnt - bc0, 1);
    check("brk_no_valid", rcv_q.size(), n0);
`else
    check("brk_pulse", brk_cnt - bc0, 0);
    expect_frame("brk", 8'h00, 1'b0, 1'b1);
`endif
    check("brk_busy_after", busy_o, 1'b0);

    // Disable during data bit 3
    n0 = rcv_q.size();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    rx_i = 1'b0; cyc(8);
    check("dis_busy_before", busy_o, 1'b1);
    rx_en_i = 1'b0;
    cyc(1);
    check("dis_busy_after", busy_o, 1'b0);
    cyc(8);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    cyc(24);
    check("dis_no_valid", rcv_q.size(), n0);
    rx_en_i = 1'b1;
    cyc(4);

    // Reset during STOP with a frame pending
    rx_if.data_ready_i = 1'b0;
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("rs_pending", rx_if.data_valid_o, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i[0]);
    rx_i = 1'b1; cyc(6);
    check("rs_busy_stop", busy_o, 1'b1);
    reset_n = 1'b0;
    cyc(1);
    check("rs_data", rx_if.data_o, 8'h00);
    check("rs_valid", rx_if.data_valid_o, 1'b0);
    check("rs_flags", {rx_if.parity_err_o, rx_if.frame_err_o, overrun_o, break_o, busy_o}, 5'b0);
    reset_n = 1'b1;
    rx_if.data_ready_i = 1'b1;
    cyc(30);

    // Randomized frames against the reference function
    for (int k = 0; k < 24; k++) begin
      d       = 8'($urandom);
      len_cfg = $urandom_range(0, 15);
      pen     = 1'($urandom_range(0, 1));
      odd     = 1'($urandom_range(0, 1));
      two     = 1'($urandom_range(0, 1));
      s1      = ($urandom_range(0, 5) != 0);
      s2      = ($urandom_range(0, 5) != 0);
      n       = (len_cfg < 5 || len_cfg > 8) ? 8 : len_cfg;
      exp     = ref_frame(d, len_cfg, pen, odd, 1'b0, s1, s2, two);
      pbit    = exp[9] ^ ($urandom_range(0, 3) == 0);
      exp     = ref_frame(d, len_cfg, pen, odd, pbit, s1, s2, two);
      data_len_i = 4'(len_cfg); parity_en_i = pen; parity_odd_i = odd; stop2_i = two;
      bc0 = brk_cnt; n0 = rcv_q.size();
      send_frame(d, n, pen, pbit, s1, s2, two);
      if (exp[10]) begin
        check($sformatf("rnd%0d_brk", k), brk_cnt - bc0, 1);
        check($sformatf("rnd%0d_novalid", k), rcv_q.size(), n0);
      end else begin
        expect_frame($sformatf("rnd%0d", k), exp[7:0], exp[9], exp[8]);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
